// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and its tick divider.
//   - State encodings of the serializer FSM (IDLE, SHIFT, DONE).
//   - cnt_width(): counter width for a modulo-n counter, never below 1 bit.
package bit_serializer_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    SHIFT = ST_SHIFT_ENC,
    DONE  = ST_DONE_ENC
  } state_e;

  // A modulo-1 counter still needs a 1-bit register so the compare is legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer_tick.sv
// tick_divider: prescaler producing a one-cycle strobe every DIV enabled cycles.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset, clears the prescaler
//   en    in  count enable; the strobe is only produced while enabled
//   clr   in  synchronous clear (frame load); has priority over en
//   tick  out high on the last cycle of each DIV-cycle period
module tick_divider
  import bit_serializer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = cnt_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          at_last;

  // With DIV=1 LAST is 0 and the counter never leaves 0, so every enabled
  // cycle is a tick.
  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & at_last;

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: loads a parallel word and shifts it out MSB first, one bit
// per DIV clock cycles, with a tick strobe marking when bit_out is valid.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset, clears all state
//   start     in  load data_in and begin a frame (only honoured in IDLE)
//   data_in   in  WIDTH-bit word, bit WIDTH-1 sent first
//   bit_out   out current serial bit (0 outside SHIFT)
//   tick      out one-cycle strobe; downstream samples bit_out when high
//   busy      out high while a frame is shifting
//   done      out one-cycle pulse after the last bit's tick
//   bits_left out bits not yet ticked out in the current frame
//   state_dbg out current FSM state encoding
// Handshake: start is a level request; it is consumed on the cycle the FSM
// is in IDLE and ignored otherwise. There is no backpressure on tick: the
// consumer must take bit_out on every cycle tick is high.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         bit_out,
  output logic                         tick,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bits_left,
  output logic [1:0]                   state_dbg
);

  localparam int BLW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BLW-1:0]   bits_left_q, bits_left_d;
  logic             load;
  logic             shifting;

  assign shifting = (state_q == SHIFT);
  assign load     = (state_q == IDLE) & start;

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .en    (shifting),
    .clr   (load),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d     = data_in;
          bits_left_d = BLW'(WIDTH);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
          bits_left_d = bits_left_q - 1'b1;
          // The last bit has just been ticked out; bits_left reaches 0 here.
          if (bits_left_q == BLW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
    end
  end

  assign busy      = shifting;
  assign done      = (state_q == DONE);
  assign bit_out   = shifting & shreg_q[WIDTH-1];
  assign bits_left = bits_left_q;
  assign state_dbg = state_q;

endmodule
